pr_stage_hs: RTL and testbench

- Parametrised successor to the fixed inter-stage pipeline registers (e.g. MEM/WB).
- Carries a DATA_W-bit payload through DEPTH register stages using a valid/ready handshake.
- Each stage has a one-entry skid buffer, so it sustains 1 beat/cycle with a fully registered up_ready_o.
- A synchronous flush squashes all in-flight beats for branch/trap recovery. Used between any two core stages that need stall and flush.

---
 rtl/pr_stage_hs.sv | 171 +++++++++++++++++
 tb/tb_pr_stage_hs.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pr_stage_hs.sv
// Valid/ready pipeline register chain: DEPTH stages, each with a one-entry skid buffer and a synchronous flush.
// Optional macro PR_STAGE_DATA_CLR_EN: payload registers return to RST_VAL whenever their valid bit clears.
module pr_stage_hs #(
  parameter int                DATA_W  = 32,
  parameter int                DEPTH   = 1,
  parameter logic [DATA_W-1:0] RST_VAL = '0,
  localparam int               OCC_W   = $clog2(2*DEPTH+1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              up_valid_i,
  output logic              up_ready_o,
  input  logic [DATA_W-1:0] up_data_i,
  output logic              dn_valid_o,
  input  logic              dn_ready_i,
  output logic [DATA_W-1:0] dn_data_o,
  output logic [OCC_W-1:0]  occupancy_o
);

  // Bit 0 = main valid, bit 1 = skid valid, so both flags are plain register bits.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL  = 2'b01,
    ST_SKID  = 2'b11
  } stage_st_e;

  localparam logic [OCC_W-1:0] OCC_ZERO = OCC_W'(0);
  localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);

  logic              main_valid_s [DEPTH];
  logic              skid_valid_s [DEPTH];
  logic [DATA_W-1:0] main_data_s  [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    stage_st_e         state_r, state_s;
    logic [DATA_W-1:0] main_r, main_s;
    logic [DATA_W-1:0] skid_r, skid_s;
    logic              in_valid_s, out_ready_s;
    logic              in_fire_s, out_fire_s;
    logic [DATA_W-1:0] in_data_s;

    if (k == 0) begin : g_head
      assign in_valid_s = up_valid_i;
      assign in_data_s  = up_data_i;
    end else begin : g_body
      assign in_valid_s = main_valid_s[k-1];
      assign in_data_s  = main_data_s[k-1];
    end

    if (k == DEPTH-1) begin : g_tail
      assign out_ready_s = dn_ready_i;
    end else begin : g_link
      assign out_ready_s = ~skid_valid_s[k+1];
    end

    assign in_fire_s  = in_valid_s & ~state_r[1];
    assign out_fire_s = state_r[0] & out_ready_s;

    // Stage next-state and payload steering; flush wins over any fire.
    always_comb begin
      state_s = state_r;
      main_s  = main_r;
      skid_s  = skid_r;
      if (flush_i) begin
        state_s = ST_EMPTY;
`ifdef PR_STAGE_DATA_CLR_EN
        main_s  = RST_VAL;
        skid_s  = RST_VAL;
`endif
      end else begin
        case (state_r)
          ST_EMPTY: begin
            if (in_fire_s) begin
              state_s = ST_FULL;
              main_s  = in_data_s;
            end else begin
              state_s = ST_EMPTY;
            end
          end
          ST_FULL: begin
            if (in_fire_s && out_fire_s) begin
              state_s = ST_FULL;
              main_s  = in_data_s;
            end else if (in_fire_s) begin
              state_s = ST_SKID;
              skid_s  = in_data_s;
            end else if (out_fire_s) begin
              state_s = ST_EMPTY;
`ifdef PR_STAGE_DATA_CLR_EN
              main_s  = RST_VAL;
`endif
            end else begin
              state_s = ST_FULL;
            end
          end
          ST_SKID: begin
            if (out_fire_s) begin
              state_s = ST_FULL;
              main_s  = skid_r;
`ifdef PR_STAGE_DATA_CLR_EN
              skid_s  = RST_VAL;
`endif
            end else begin
              state_s = ST_SKID;
            end
          end
          default: begin
            // Unreachable encoding 2'b10: drop back to a clean empty stage.
            state_s = ST_EMPTY;
            main_s  = RST_VAL;
            skid_s  = RST_VAL;
          end
        endcase
      end
    end

    // Stage state and payload registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_r <= ST_EMPTY;
        main_r  <= RST_VAL;
        skid_r  <= RST_VAL;
      end else begin
        state_r <= state_s;
        main_r  <= main_s;
        skid_r  <= skid_s;
      end
    end

    assign main_valid_s[k] = state_r[0];
    assign skid_valid_s[k] = state_r[1];
    assign main_data_s[k]  = main_r;
  end

  logic             up_fire_s, dn_fire_s;
  logic [OCC_W-1:0] occ_r, occ_s;

  assign up_ready_o = ~skid_valid_s[0];
  assign dn_valid_o = main_valid_s[DEPTH-1];
  assign dn_data_o  = main_data_s[DEPTH-1];

  assign up_fire_s = up_valid_i & up_ready_o;
  assign dn_fire_s = dn_valid_o & dn_ready_i;

  // Occupancy tracks up/down fires and is forced to zero by flush.
  always_comb begin
    occ_s = occ_r;
    if (flush_i) begin
      occ_s = OCC_ZERO;
    end else if (up_fire_s && !dn_fire_s) begin
      occ_s = occ_r + OCC_ONE;
    end else if (!up_fire_s && dn_fire_s) begin
      occ_s = occ_r - OCC_ONE;
    end else begin
      occ_s = occ_r;
    end
  end

  // Occupancy register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_r <= OCC_ZERO;
    end else begin
      occ_r <= occ_s;
    end
  end

  assign occupancy_o = occ_r;

endmodule

// File: tb/tb_pr_stage_hs.sv
// Bench for pr_stage_hs: DEPTH 1/2/3 instances share one stimulus stream; directed cases plus a random
// run scored against a per-instance array FIFO model.
module tb_pr_stage_hs;
  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          flush;
  logic          up_valid;
  logic          dn_ready;
  logic [DW-1:0] up_data;
  logic          urdy [3];
  logic          dvld [3];
  logic [DW-1:0] ddat [3];
  logic [1:0]    occ1;
  logic [2:0]    occ2, occ3;
  logic [2:0]    occ [3];

  int total = 0;
  int bad   = 0;

  always_comb begin
    occ[0] = {1'b0, occ1};
    occ[1] = occ2;
    occ[2] = occ3;
  end

  pr_stage_hs #(.DATA_W(DW), .DEPTH(1), .RST_VAL(16'h0000)) u_d1 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .up_valid_i(up_valid), .up_ready_o(urdy[0]),
    .up_data_i(up_data), .dn_valid_o(dvld[0]), .dn_ready_i(dn_ready), .dn_data_o(ddat[0]),
    .occupancy_o(occ1));

  pr_stage_hs #(.DATA_W(DW), .DEPTH(2), .RST_VAL(16'hDEAD)) u_d2 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .up_valid_i(up_valid), .up_ready_o(urdy[1]),
    .up_data_i(up_data), .dn_valid_o(dvld[1]), .dn_ready_i(dn_ready), .dn_data_o(ddat[1]),
    .occupancy_o(occ2));

  pr_stage_hs #(.DATA_W(DW), .DEPTH(3), .RST_VAL(16'h0000)) u_d3 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .up_valid_i(up_valid), .up_ready_o(urdy[2]),
    .up_data_i(up_data), .dn_valid_o(dvld[2]), .dn_ready_i(dn_ready), .dn_data_o(ddat[2]),
    .occupancy_o(occ3));

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic r, input logic f);
    up_valid = v;
    up_data  = d;
    dn_ready = r;
    flush    = f;
  endtask

  task automatic flush_all();
    drive(1'b0, 16'h0000, 1'b1, 1'b1);
    tick();
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
  endtask

  logic [DW-1:0] mem [3][4096];
  int wr [3];
  int rd [3];
  int depth_of [3];
  int occ_e [6];
  int first_seen [3];
  int outs3;
  int cnt;

  initial begin
    depth_of = '{1, 2, 3};
    occ_e    = '{1, 2, 2, 1, 0, 0};
    rst_n = 1'b0;
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    tick();
    tick();

    check_eq("rst_rdy", urdy[0], 1);
    check_eq("rst_vld", dvld[0], 0);
    check_eq("rst_data", ddat[0], 0);
    check_eq("rst_occ", occ[0], 0);
    check_eq("rst_data_d2", ddat[1], 16'hDEAD);
    check_eq("rst_rdy_d3", urdy[2], 1);
    rst_n = 1'b1;
    tick();

    // DEPTH=2 streaming at full rate
    for (int i = 0; i < 6; i++) begin
      drive(i < 3, 16'h0010 + 16'(i), 1'b1, 1'b0);
      tick();
      check_eq($sformatf("stream_vld%0d", i), dvld[1], (i >= 1 && i <= 3));
      if (i >= 1 && i <= 3) check_eq($sformatf("stream_data%0d", i), ddat[1], 16'h0010 + i - 1);
      check_eq($sformatf("stream_occ%0d", i), occ[1], occ_e[i]);
      check_eq($sformatf("stream_rdy%0d", i), urdy[1], 1);
    end
    flush_all();

    // DEPTH=1 backpressure into the skid buffer
    drive(1'b1, 16'h000A, 1'b0, 1'b0);
    check_eq("bp_rdy_a", urdy[0], 1);
    tick();
    drive(1'b1, 16'h000B, 1'b0, 1'b0);
    check_eq("bp_rdy_b", urdy[0], 1);
    tick();
    check_eq("bp_rdy_full", urdy[0], 0);
    check_eq("bp_occ_full", occ[0], 2);
    check_eq("bp_vld", dvld[0], 1);
    check_eq("bp_data_a", ddat[0], 16'h000A);
    drive(1'b1, 16'h000C, 1'b0, 1'b0);
    tick();
    check_eq("bp_hold_rdy", urdy[0], 0);
    check_eq("bp_hold_occ", occ[0], 2);
    check_eq("bp_hold_data", ddat[0], 16'h000A);
    drive(1'b1, 16'h000C, 1'b1, 1'b0);
    tick();
    check_eq("bp_data_b", ddat[0], 16'h000B);
    check_eq("bp_occ_b", occ[0], 1);
    check_eq("bp_rdy_b2", urdy[0], 1);
    tick();
    check_eq("bp_data_c", ddat[0], 16'h000C);
    check_eq("bp_occ_c", occ[0], 1);
    drive(1'b0, 16'h0000, 1'b1, 1'b0);
    tick();
    check_eq("bp_empty_vld", dvld[0], 0);
    check_eq("bp_empty_occ", occ[0], 0);
    flush_all();

    // DEPTH=2 filled to capacity, then flushed while both sides would fire
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 16'(i + 1), 1'b0, 1'b0);
      tick();
    end
    check_eq("fl_occ_full", occ[1], 4);
    check_eq("fl_rdy_full", urdy[1], 0);
    check_eq("fl_head", ddat[1], 16'h0001);
    drive(1'b1, 16'h0055, 1'b1, 1'b1);
    tick();
    drive(1'b0, 16'h0000, 1'b1, 1'b0);
    check_eq("fl_vld", dvld[1], 0);
    check_eq("fl_occ", occ[1], 0);
    check_eq("fl_rdy", urdy[1], 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq($sformatf("fl_no55_%0d", i), dvld[1], 0);
    end
    flush_all();

    // Payload after the last beat drains
    drive(1'b1, 16'h1234, 1'b1, 1'b0);
    tick();
    drive(1'b0, 16'h0000, 1'b1, 1'b0);
    tick();
    check_eq("clr_vld", dvld[1], 1);
    check_eq("clr_data", ddat[1], 16'h1234);
    tick();
    check_eq("clr_vld_after", dvld[1], 0);
`ifdef PR_STAGE_DATA_CLR_EN
    check_eq("clr_data_after", ddat[1], 16'hDEAD);
`else
    check_eq("clr_data_after", ddat[1], 16'h1234);
`endif
    flush_all();

    // Empty-pipe latency on every depth
    drive(1'b1, 16'h0077, 1'b1, 1'b0);
    tick();
    drive(1'b0, 16'h0000, 1'b1, 1'b0);
    first_seen = '{-1, -1, -1};
    for (int c = 1; c <= 12; c++) begin
      for (int d = 0; d < 3; d++) begin
        if (dvld[d] && first_seen[d] < 0) first_seen[d] = c;
      end
      tick();
    end
    for (int d = 0; d < 3; d++) begin
      check_eq($sformatf("lat_d%0d", d + 1), first_seen[d], depth_of[d]);
    end
    flush_all();

    // Reset asserted mid-stream clears outputs immediately
    drive(1'b1, 16'h00AB, 1'b0, 1'b0);
    tick();
    tick();
    check_eq("mrst_pre_occ", occ[0], 2);
    rst_n = 1'b0;
    #1;
    check_eq("mrst_rdy", urdy[0], 1);
    check_eq("mrst_vld", dvld[0], 0);
    check_eq("mrst_data", ddat[0], 0);
    check_eq("mrst_occ", occ[0], 0);
    check_eq("mrst_occ_d3", occ[2], 0);
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    #2;
    rst_n = 1'b1;
    tick();

    // Random valid/ready/flush against the FIFO model
    wr    = '{0, 0, 0};
    rd    = '{0, 0, 0};
    outs3 = 0;
    for (int c = 0; c < 40000 && outs3 < 1000; c++) begin
      drive($urandom_range(0, 9) < 7, 16'($urandom), $urandom_range(0, 9) < 6,
            $urandom_range(0, 255) == 0);
      for (int d = 0; d < 3; d++) begin
        cnt = wr[d] - rd[d];
        check_eq($sformatf("rnd_occ_d%0d", d + 1), occ[d], cnt);
        check_eq($sformatf("rnd_phantom_d%0d", d + 1), dvld[d] && (cnt == 0), 0);
        if (cnt == 2 * depth_of[d]) check_eq($sformatf("rnd_full_rdy_d%0d", d + 1), urdy[d], 0);
        if (flush) begin
          rd[d] = wr[d];
        end else begin
          if (dvld[d] && dn_ready) begin
            if (cnt > 0) begin
              check_eq($sformatf("rnd_data_d%0d", d + 1), ddat[d], mem[d][rd[d] % 4096]);
              rd[d]++;
            end
            if (d == 2) outs3++;
          end
          if (up_valid && urdy[d]) begin
            mem[d][wr[d] % 4096] = up_data;
            wr[d]++;
          end
        end
      end
      tick();
    end
    check_eq("rnd_done", outs3 >= 1000, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
